md_scheduler: RTL

- Multi-cycle multiply/divide controller beside the EX-stage ALU.
- Owns the HI/LO registers and sequences MULT/MULTU/DIV/DIVU over a fixed number of cycles.
- Executes MTHI/MTLO in a single cycle.
- Drives the stall that holds a later HI/LO-dependent instruction in decode, resolving the EX-stage "mult/div module stalls" item.

---
 rtl/md_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/md_scheduler.sv
// md_scheduler: multi-cycle multiply/divide controller that owns HI/LO.
// Ports:
//   clk, reset           - clock (rising edge), async active-low reset
//   start, op            - EX-stage md instruction valid and its opcode
//   dataA, dataB         - forwarded rs / rt operands
//   md_use_ID            - decode-stage instruction touches the md unit
//   busy                 - multi-cycle operation in progress (from state reg)
//   stall                - combinational hold of IF/ID, bubble into EX
//   hi, lo               - architectural HI/LO registers
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic        md_use_ID,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned OW = 3;

  localparam logic [OW-1:0] OP_MULT  = 3'd1;
  localparam logic [OW-1:0] OP_MULTU = 3'd2;
  localparam logic [OW-1:0] OP_DIV   = 3'd3;
  localparam logic [OW-1:0] OP_DIVU  = 3'd4;
  localparam logic [OW-1:0] OP_MTHI  = 3'd5;
  localparam logic [OW-1:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [OW-1:0]    r_op;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;

  logic             w_start_md;
  logic             w_accept;
  logic             w_done;

  // Start of a multi-cycle op (ops 1..4) presented this cycle
  assign w_start_md = start & (op inside {[OP_MULT:OP_DIVU]});
  assign w_accept   = (r_state == S_IDLE) & w_start_md;
  assign w_done     = (r_state == S_RUN) & (r_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_md) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: busy follows the state flop; stall also covers the entry cycle
  always_comb begin
    busy  = (r_state == S_RUN);
    stall = reset & md_use_ID & (busy | w_start_md);
  end

  // Operand latch and cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_accept) begin
      r_op  <= op;
      r_a   <= dataA;
      r_b   <= dataB;
      r_cnt <= (op == OP_MULT || op == OP_MULTU) ? CNT_W'(MULT_CYCLES - 1)
                                                 : CNT_W'(DIV_CYCLES - 1);
    end else if (r_state == S_RUN && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Result arithmetic from latched operands; divide is done on magnitudes
  // so that 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  logic [2*W-1:0] w_prod_s;
  logic [2*W-1:0] w_prod_u;
  logic           w_signed_div;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [W-1:0]   w_num;
  logic [W-1:0]   w_den;
  logic [W-1:0]   w_den_safe;
  logic [W-1:0]   w_q_mag;
  logic [W-1:0]   w_r_mag;
  logic [W-1:0]   w_quot;
  logic [W-1:0]   w_rem;

  always_comb begin
    w_prod_s     = 64'($signed(r_a)) * 64'($signed(r_b));
    w_prod_u     = 64'(r_a) * 64'(r_b);
    w_signed_div = (r_op == OP_DIV);
    w_a_neg      = w_signed_div & r_a[W-1];
    w_b_neg      = w_signed_div & r_b[W-1];
    w_num        = w_a_neg ? (W'(0) - r_a) : r_a;
    w_den        = w_b_neg ? (W'(0) - r_b) : r_b;
    w_den_safe   = (w_den == '0) ? W'(1) : w_den;
    w_q_mag      = w_num / w_den_safe;
    w_r_mag      = w_num % w_den_safe;
    w_quot       = (w_a_neg ^ w_b_neg) ? (W'(0) - w_q_mag) : w_q_mag;
    w_rem        = w_a_neg ? (W'(0) - w_r_mag) : w_r_mag;
  end

  // HI/LO: written on completion (skipped on divide by zero) or MTHI/MTLO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      unique case (r_op)
        OP_MULT:  {r_hi, r_lo} <= w_prod_s;
        OP_MULTU: {r_hi, r_lo} <= w_prod_u;
        OP_DIV, OP_DIVU: begin
          if (r_b != '0) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
        end
        default: ;
      endcase
    end else if (r_state == S_IDLE && start) begin
      if (op == OP_MTHI) r_hi <= dataA;
      if (op == OP_MTLO) r_lo <= dataA;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
